ladybird_bus_arbiter: RTL and testbench
=======================================

Name: ladybird_bus_arbiter

Overview:
Shares one peripheral bus port between N_REQ core-side requesters using a registered round-robin arbiter with one outstanding transaction. It replaces fixed-priority sharing in front of a single peripheral, such as memory or UART, and sits between the crossbar's core side and that peripheral. It uses the same req/gnt/data_gnt protocol: stores complete at the peripheral gnt, and loads complete at the peripheral data_gnt. A response timeout prevents a dead peripheral from hanging a core.

Parameters:
N_REQ, 2, number of requesters (>=2)
TIMEOUT, 1024, max cycles in WAIT_DATA before an error response; 0 disables the timeout

Ports:
clk  input  1  clock; all state updates on posedge
arst  input  1  reset, asynchronous, active-high
core_req  input  N_REQ  per-requester request; held with payload until core_gnt
core_addr  input  N_REQ*32  packed per-requester address
core_wstrb  input  N_REQ*4  packed byte strobes; nonzero means store, zero means load
core_wdata  input  N_REQ*32  packed store data
core_gnt  output  N_REQ  one-hot capture pulse
core_data_gnt  output  N_REQ  one-hot load-response pulse
core_rdata  output  32  load data, broadcast; valid with core_data_gnt
core_err  output  1  pulses with core_data_gnt on a timeout response
busy  output  1  high in any state other than IDLE
p_req  output  1  peripheral request
p_addr  output  32  peripheral address
p_wstrb  output  4  peripheral strobes
p_wdata  output  32  peripheral store data
p_gnt  input  1  peripheral accepts the request
p_data_gnt  input  1  peripheral load data valid
p_rdata  input  32  peripheral load data

Behaviour:
- Reset: on arst, asynchronously set state=IDLE, rr_ptr=0, owner=0, timeout count=0, and payload registers=0. All outputs are 0 while reset is asserted and in the first cycle after release.
- States: IDLE, ISSUE, WAIT_DATA.
- IDLE, cycle T, selection:
  - If any core_req is high, select the first index with req=1 scanning rr_ptr, rr_ptr+1, ..., wrapping modulo N_REQ.
  - Drive core_gnt[sel]=1 combinationally in T.
  - Register owner=sel, addr, wstrb and wdata.
  - Set rr_ptr = sel+1, wrapping N_REQ-1 to 0.
  - Go to ISSUE.
  - If no core_req is high: no gnt, stay in IDLE.
- ISSUE:
  - p_req=1; p_addr, p_wstrb and p_wdata come from the registers; the first p_req is at T+1.
  - On p_gnt with a store (wstrb!=0): go to IDLE. There is no core response.
  - On p_gnt with a load: clear the timeout count and go to WAIT_DATA.
  - p_data_gnt is ignored in ISSUE.
- p_wdata is 0 for loads; p_addr, p_wstrb and p_wdata are 0 whenever p_req=0.
- WAIT_DATA:
  - p_req=0; the timeout count increments each cycle.
  - On p_data_gnt: core_data_gnt[owner]=1 and core_rdata=p_rdata combinationally in the same cycle; go to IDLE.
  - If TIMEOUT!=0, the count reaches TIMEOUT-1 and p_data_gnt=0: core_data_gnt[owner]=1, core_rdata=0, core_err=1; go to IDLE.
  - If p_data_gnt and timeout expiry coincide, the data wins and core_err=0.
- core_rdata is 0 whenever no core_data_gnt is asserted.
- Fairness: a requester holding req waits at most N_REQ-1 other transactions.
- Back-to-back throughput: a store takes at least 2 cycles (IDLE, ISSUE with p_gnt); a load takes at least 3.
- Count width: $clog2(TIMEOUT+1), with a minimum of 1.
- Requester protocol:
  - A requester must not drop req before gnt.
  - A load requester must not issue a new request before its data_gnt.
  - The arbiter does not check either rule.
- A late p_data_gnt arriving in IDLE or ISSUE after a timeout is ignored.
- Reset mid-transaction: the transaction is abandoned and no response is generated.

Decomposition:
- ladybird_config package gets:
  - arb_state_t enum (IDLE, ISSUE, WAIT_DATA);
  - ARB_TIMEOUT_RDATA = 32'h0.
- One combinational sub-module, ladybird_rr_select (parameter N):
  - inputs: req vector, ptr;
  - outputs: any, sel index.

Test Plan:
1. Single load, N_REQ=2: core_req=01, addr=0x8000_0010, wstrb=0. core_gnt=01 at T, p_req at T+1. p_gnt at T+1, p_data_gnt with 0x1234_5678 at T+3. Expect core_data_gnt=01 at T+3 with rdata 0x1234_5678, core_err=0, busy low at T+4.
2. Round-robin: core_req=11 held, all stores, p_gnt always 1. Expect the core_gnt sequence 01, 10, 01, 10 at 2-cycle spacing. Then core_req=10 only: expect grant to index 1 regardless of rr_ptr.
3. Store: wstrb=0xF, wdata=0xCAFE_F00D, p_gnt delayed 3 cycles. Expect p_req held 3 cycles with stable payload, no core_data_gnt, and IDLE the cycle after p_gnt.
4. Timeout, TIMEOUT=8: load with p_gnt but no p_data_gnt. Expect core_data_gnt[owner] and core_err at the 8th WAIT_DATA cycle with rdata=0. A later p_data_gnt is ignored.
5. Coincidence: p_data_gnt at exactly the expiry cycle with data 0xA5A5_A5A5. Expect rdata=0xA5A5_A5A5 and core_err=0.
6. Reset: assert arst during WAIT_DATA. Expect all outputs 0 immediately, state IDLE and rr_ptr=0 after release. The next request from index 0 is granted first.

Source files
------------

// File: rtl/ladybird_bus_arbiter_pkg.sv
// Shared types and constants for the ladybird peripheral bus arbiter.
package ladybird_config;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DATA
  } arb_state_t;

  // Load data returned to the core when the peripheral never answers.
  localparam logic [31:0] ARB_TIMEOUT_RDATA = 32'h0;

endpackage

// File: rtl/ladybird_rr_select.sv
// Round-robin pick: first requester at or after ptr, wrapping modulo N.
module ladybird_rr_select #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] sel
);

  always_comb begin
    int unsigned idx;
    logic [N-1:0] rotated;
    idx     = 0;
    rotated = '0;
    any     = |req;
    sel     = '0;
    // Scan from the farthest offset down so the nearest hit to ptr wins.
    for (int k = N - 1; k >= 0; k--) begin
      idx     = (int'(ptr) + k) % N;
      rotated = req >> idx;
      if (rotated[0]) sel = IW'(idx);
    end
  end

endmodule

// File: rtl/ladybird_bus_arbiter.sv
// Round-robin arbiter sharing one peripheral port among N_REQ cores, with
// a single outstanding transaction and a load-response timeout.
module ladybird_bus_arbiter
  import ladybird_config::*;
#(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                arst,
  input  logic [N_REQ-1:0]    core_req,
  input  logic [N_REQ*32-1:0] core_addr,
  input  logic [N_REQ*4-1:0]  core_wstrb,
  input  logic [N_REQ*32-1:0] core_wdata,
  output logic [N_REQ-1:0]    core_gnt,
  output logic [N_REQ-1:0]    core_data_gnt,
  output logic [31:0]         core_rdata,
  output logic                core_err,
  output logic                busy,
  output logic                p_req,
  output logic [31:0]         p_addr,
  output logic [3:0]          p_wstrb,
  output logic [31:0]         p_wdata,
  input  logic                p_gnt,
  input  logic                p_data_gnt,
  input  logic [31:0]         p_rdata
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  arb_state_t       state_reg;
  logic             run_reg;
  logic [IDX_W-1:0] rr_ptr_reg;
  logic [IDX_W-1:0] owner_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [31:0]      addr_reg;
  logic [3:0]       wstrb_reg;
  logic [31:0]      wdata_reg;

  logic [31:0] addr_arr  [N_REQ];
  logic [3:0]  wstrb_arr [N_REQ];
  logic [31:0] wdata_arr [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = core_addr[gi*32 +: 32];
    assign wstrb_arr[gi] = core_wstrb[gi*4 +: 4];
    assign wdata_arr[gi] = core_wdata[gi*32 +: 32];
  end

  logic             sel_any;
  logic [IDX_W-1:0] sel_idx;

  ladybird_rr_select #(.N(N_REQ)) u_rr_select (
    .req (core_req),
    .ptr (rr_ptr_reg),
    .any (sel_any),
    .sel (sel_idx)
  );

  // run_reg keeps every output quiet during the first cycle out of reset.
  logic grant;
  logic expire;
  logic respond;

  assign grant   = run_reg && (state_reg == IDLE) && sel_any;
  assign expire  = (TIMEOUT != 0) && (cnt_reg == CNT_LAST);
  assign respond = (state_reg == WAIT_DATA) && (p_data_gnt || expire);

  assign core_gnt      = grant ? (N_REQ'(1) << sel_idx) : '0;
  assign core_data_gnt = respond ? (N_REQ'(1) << owner_reg) : '0;
  assign core_rdata    = respond ? (p_data_gnt ? p_rdata : ARB_TIMEOUT_RDATA) : '0;
  assign core_err      = respond && !p_data_gnt;
  assign busy          = (state_reg != IDLE);

  assign p_req   = (state_reg == ISSUE);
  assign p_addr  = p_req ? addr_reg  : '0;
  assign p_wstrb = p_req ? wstrb_reg : '0;
  assign p_wdata = p_req ? wdata_reg : '0;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_reg  <= IDLE;
      run_reg    <= 1'b0;
      rr_ptr_reg <= '0;
      owner_reg  <= '0;
      cnt_reg    <= '0;
      addr_reg   <= '0;
      wstrb_reg  <= '0;
      wdata_reg  <= '0;
    end else begin
      run_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (grant) begin
            owner_reg  <= sel_idx;
            addr_reg   <= addr_arr[sel_idx];
            wstrb_reg  <= wstrb_arr[sel_idx];
            wdata_reg  <= (wstrb_arr[sel_idx] != '0) ? wdata_arr[sel_idx] : '0;
            rr_ptr_reg <= (sel_idx == LAST_IDX) ? '0 : sel_idx + IDX_W'(1);
            state_reg  <= ISSUE;
          end
        end
        ISSUE: begin
          if (p_gnt) begin
            cnt_reg   <= '0;
            state_reg <= (wstrb_reg != '0) ? IDLE : WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (respond) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ladybird_bus_arbiter.sv
// Directed cycle-by-cycle bench for ladybird_bus_arbiter (N_REQ=2, TIMEOUT=8).
module tb_ladybird_bus_arbiter;

  localparam int N  = 2;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          arst = 1'b1;
  logic [N-1:0]  core_req = '0;
  logic [N*32-1:0] core_addr = '0;
  logic [N*4-1:0]  core_wstrb = '0;
  logic [N*32-1:0] core_wdata = '0;
  logic [N-1:0]  core_gnt;
  logic [N-1:0]  core_data_gnt;
  logic [31:0]   core_rdata;
  logic          core_err;
  logic          busy;
  logic          p_req;
  logic [31:0]   p_addr;
  logic [3:0]    p_wstrb;
  logic [31:0]   p_wdata;
  logic          p_gnt = 1'b0;
  logic          p_data_gnt = 1'b0;
  logic [31:0]   p_rdata = '0;

  always #5 clk = ~clk;

  ladybird_bus_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .arst          (arst),
    .core_req      (core_req),
    .core_addr     (core_addr),
    .core_wstrb    (core_wstrb),
    .core_wdata    (core_wdata),
    .core_gnt      (core_gnt),
    .core_data_gnt (core_data_gnt),
    .core_rdata    (core_rdata),
    .core_err      (core_err),
    .busy          (busy),
    .p_req         (p_req),
    .p_addr        (p_addr),
    .p_wstrb       (p_wstrb),
    .p_wdata       (p_wdata),
    .p_gnt         (p_gnt),
    .p_data_gnt    (p_data_gnt),
    .p_rdata       (p_rdata)
  );

  // Requester 1 sees addr+0x100 and ~wdata; requester 0 sees the raw fields.
  typedef struct {
    string       name;
    logic [1:0]  req;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        pg;
    logic        pdg;
    logic [31:0] prdata;
    logic [1:0]  e_gnt;
    logic [1:0]  e_dgnt;
    logic [31:0] e_rdata;
    logic        e_err;
    logic        e_busy;
    logic        e_preq;
    logic [31:0] e_paddr;
    logic [3:0]  e_pwstrb;
    logic [31:0] e_pwdata;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs[21];

  function automatic vec_t mk(input string name, input logic [1:0] req, input logic [31:0] addr,
                              input logic [3:0] wstrb, input logic [31:0] wdata, input logic pg,
                              input logic pdg, input logic [31:0] prdata, input logic [1:0] e_gnt,
                              input logic [1:0] e_dgnt, input logic [31:0] e_rdata, input logic e_err,
                              input logic e_busy, input logic e_preq, input logic [31:0] e_paddr,
                              input logic [3:0] e_pwstrb, input logic [31:0] e_pwdata);
    vec_t v;
    v.name = name; v.req = req; v.addr = addr; v.wstrb = wstrb; v.wdata = wdata;
    v.pg = pg; v.pdg = pdg; v.prdata = prdata;
    v.e_gnt = e_gnt; v.e_dgnt = e_dgnt; v.e_rdata = e_rdata; v.e_err = e_err;
    v.e_busy = e_busy; v.e_preq = e_preq; v.e_paddr = e_paddr;
    v.e_pwstrb = e_pwstrb; v.e_pwdata = e_pwdata;
    return v;
  endfunction

  task automatic cmp(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %h expected %h", tag, what, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    core_req   = v.req;
    core_addr  = {v.addr + 32'h100, v.addr};
    core_wstrb = {v.wstrb, v.wstrb};
    core_wdata = {~v.wdata, v.wdata};
    p_gnt      = v.pg;
    p_data_gnt = v.pdg;
    p_rdata    = v.prdata;
  endtask

  task automatic check(input vec_t v);
    $display("[TB] %s gnt=%b dgnt=%b rdata=%h err=%b busy=%b p_req=%b p_addr=%h p_wstrb=%h p_wdata=%h",
             v.name, core_gnt, core_data_gnt, core_rdata, core_err, busy, p_req, p_addr, p_wstrb, p_wdata);
    cmp(v.name, "core_gnt",      32'(core_gnt),      32'(v.e_gnt));
    cmp(v.name, "core_data_gnt", 32'(core_data_gnt), 32'(v.e_dgnt));
    cmp(v.name, "core_rdata",    core_rdata,         v.e_rdata);
    cmp(v.name, "core_err",      32'(core_err),      32'(v.e_err));
    cmp(v.name, "busy",          32'(busy),          32'(v.e_busy));
    cmp(v.name, "p_req",         32'(p_req),         32'(v.e_preq));
    cmp(v.name, "p_addr",        p_addr,             v.e_paddr);
    cmp(v.name, "p_wstrb",       32'(p_wstrb),       32'(v.e_pwstrb));
    cmp(v.name, "p_wdata",       p_wdata,            v.e_pwdata);
  endtask

  task automatic step(input vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    check(v);
  endtask

  initial begin
    vec_t v;
    // Round-robin stores, p_gnt always high: 01,10,01,10 then only req 1.
    vecs[0]  = mk("rr_g0",  2'b11, 32'h1000_0000, 4'hF, 32'hDEAD_0000, 1, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk("rr_i0",  2'b11, 32'h1000_0000, 4'hF, 32'hDEAD_0000, 1, 0, 0, 2'b00, 0, 0, 0, 1, 1, 32'h1000_0000, 4'hF, 32'hDEAD_0000);
    vecs[2]  = mk("rr_g1",  2'b11, 32'h1000_0000, 4'hF, 32'hDEAD_0000, 1, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[3]  = mk("rr_i1",  2'b11, 32'h1000_0000, 4'hF, 32'hDEAD_0000, 1, 0, 0, 2'b00, 0, 0, 0, 1, 1, 32'h1000_0100, 4'hF, 32'h2152_FFFF);
    vecs[4]  = mk("rr_g0b", 2'b11, 32'h1000_0000, 4'hF, 32'hDEAD_0000, 1, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[5]  = mk("rr_i0b", 2'b11, 32'h1000_0000, 4'hF, 32'hDEAD_0000, 1, 0, 0, 2'b00, 0, 0, 0, 1, 1, 32'h1000_0000, 4'hF, 32'hDEAD_0000);
    vecs[6]  = mk("rr_g1b", 2'b11, 32'h1000_0000, 4'hF, 32'hDEAD_0000, 1, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mk("rr_i1b", 2'b11, 32'h1000_0000, 4'hF, 32'hDEAD_0000, 1, 0, 0, 2'b00, 0, 0, 0, 1, 1, 32'h1000_0100, 4'hF, 32'h2152_FFFF);
    vecs[8]  = mk("only1_g", 2'b10, 32'h1000_0000, 4'hF, 32'hDEAD_0000, 1, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[9]  = mk("only1_i", 2'b10, 32'h1000_0000, 4'hF, 32'hDEAD_0000, 1, 0, 0, 2'b00, 0, 0, 0, 1, 1, 32'h1000_0100, 4'hF, 32'h2152_FFFF);
    vecs[10] = mk("idle1",  2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    // Single load: early p_data_gnt in ISSUE is ignored, wdata forced to 0.
    vecs[11] = mk("ld_g",     2'b01, 32'h8000_0010, 4'h0, 32'hFFFF_FFFF, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[12] = mk("ld_issue", 2'b00, 32'h8000_0010, 4'h0, 32'hFFFF_FFFF, 1, 1, 32'hBAD0_BAD0, 2'b00, 0, 0, 0, 1, 1, 32'h8000_0010, 4'h0, 32'h0);
    vecs[13] = mk("ld_wait",  2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0);
    vecs[14] = mk("ld_data",  2'b00, 0, 0, 0, 0, 1, 32'h1234_5678, 2'b00, 2'b01, 32'h1234_5678, 0, 1, 0, 0, 0, 0);
    vecs[15] = mk("ld_idle",  2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    // Store with p_gnt delayed 3 cycles; late p_data_gnt in IDLE ignored.
    vecs[16] = mk("st_g",    2'b01, 32'h4000_0020, 4'hF, 32'hCAFE_F00D, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[17] = mk("st_w1",   2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 1, 32'h4000_0020, 4'hF, 32'hCAFE_F00D);
    vecs[18] = mk("st_w2",   2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 1, 32'h4000_0020, 4'hF, 32'hCAFE_F00D);
    vecs[19] = mk("st_gnt",  2'b00, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 1, 1, 32'h4000_0020, 4'hF, 32'hCAFE_F00D);
    vecs[20] = mk("st_idle", 2'b00, 0, 0, 0, 0, 1, 32'hFFFF_FFFF, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset asserted with every input active: all outputs stay 0.
    v = mk("reset_hold", 2'b11, 32'h1000_0000, 4'hF, 32'h1, 1, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    drive(v);
    #1;
    check(v);
    @(negedge clk);
    arst = 1'b0;
    v.name = "reset_release";
    drive(v);
    #1;
    check(v);

    for (int i = 0; i < 21; i++) step(vecs[i]);

    // Timeout: load from requester 1, no data; error on 8th WAIT_DATA cycle.
    step(mk("to_g", 2'b10, 32'h5000_0000, 4'h0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0));
    step(mk("to_issue", 2'b00, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 32'h5000_0100, 4'h0, 32'h0));
    for (int k = 1; k <= TO; k++)
      step(mk($sformatf("to_wait%0d", k), 2'b00, 0, 0, 0, 0, 0, 0, 0,
              (k == TO) ? 2'b10 : 2'b00, 0, (k == TO), 1, 0, 0, 0, 0));
    step(mk("to_late", 2'b00, 0, 0, 0, 0, 1, 32'h1111_1111, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Data arriving exactly at the expiry cycle wins over the timeout.
    step(mk("co_g", 2'b01, 32'h6000_0000, 4'h0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0));
    step(mk("co_issue", 2'b00, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 32'h6000_0000, 4'h0, 32'h0));
    for (int k = 1; k < TO; k++)
      step(mk($sformatf("co_wait%0d", k), 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    step(mk("co_data", 2'b00, 0, 0, 0, 0, 1, 32'hA5A5_A5A5, 0, 2'b01, 32'hA5A5_A5A5, 0, 1, 0, 0, 0, 0));
    step(mk("co_idle", 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Reset during WAIT_DATA: outputs drop at once; rr_ptr returns to 0.
    step(mk("rs_g", 2'b01, 32'h7000_0000, 4'h0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0));
    step(mk("rs_issue", 2'b00, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 32'h7000_0000, 4'h0, 32'h0));
    step(mk("rs_pre", 2'b00, 0, 0, 0, 0, 1, 32'h7777_7777, 0, 2'b01, 32'h7777_7777, 0, 1, 0, 0, 0, 0));
    arst = 1'b1;
    #1;
    check(mk("rs_async", 2'b00, 0, 0, 0, 0, 1, 32'h7777_7777, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    arst = 1'b0;
    v = mk("rs_release", 2'b11, 32'h7000_0000, 4'hF, 32'h0BAD_F00D, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(v);
    #1;
    check(v);
    step(mk("rs_first", 2'b11, 32'h7000_0000, 4'hF, 32'h0BAD_F00D, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0));
    step(mk("rs_st", 2'b00, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 32'h7000_0000, 4'hF, 32'h0BAD_F00D));
    step(mk("rs_idle", 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
